gen_scheduler: RTL and testbench

Generation scheduler that sequences the Game of Life datapath: it decides when `life_logic` computes the next generation and when the double buffer swaps, paced by frame completions from the renderer and the user speed setting. It supports pause and single-step, and has a compute watchdog. It sits between `user_interface`, `renderer`, `life_logic` and `double_buffer`. Its start/swap outputs drive `life_logic.start_in` and `double_buffer.swap_in`.

---
 rtl/gen_scheduler_if.sv | 32 +++
 rtl/gen_scheduler.sv | 151 +++++++++++++++
 tb/tb_gen_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_scheduler_if.sv
// Control bundle between the generation scheduler and its neighbours
// (user interface, renderer, life logic, double buffer).
interface gen_scheduler_if #(
  parameter int unsigned SPEED_W = 4,
  parameter int unsigned GEN_W   = 16
);
  // Towards the scheduler
  logic [SPEED_W-1:0] speed_in;
  logic               pause_in;
  logic               step_in;
  logic               render_done_in;
  logic               logic_done_in;
  logic               buf_ready_in;
  // From the scheduler
  logic               logic_start_out;
  logic               buf_swap_out;
  logic               busy_out;
  logic [GEN_W-1:0]   gen_count_out;
  logic               error_out;

  // Environment side: drives the requests and completions, observes the controls
  modport master (
    output speed_in, pause_in, step_in, render_done_in, logic_done_in, buf_ready_in,
    input  logic_start_out, buf_swap_out, busy_out, gen_count_out, error_out
  );

  // Scheduler side
  modport slave (
    input  speed_in, pause_in, step_in, render_done_in, logic_done_in, buf_ready_in,
    output logic_start_out, buf_swap_out, busy_out, gen_count_out, error_out
  );
endinterface

// File: rtl/gen_scheduler.sv
// Generation scheduler: paces life_logic generations against renderer frames,
// gates buffer swaps on frame boundaries, supports pause/single-step and
// aborts a generation whose compute phase exceeds the watchdog limit.
module gen_scheduler #(
  parameter int unsigned SPEED_W   = 4,
  parameter int unsigned GEN_W     = 16,
  parameter int unsigned TIMEOUT_W = 24
) (
  input  logic              clk_in,
  input  logic              rst_in,
  gen_scheduler_if.slave    bus
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StCompute,
    StWaitSwap,
    StSwap
  } state_e;

  // 2^SPEED_W, one bit wider than the speed field so the period never wraps
  localparam logic [SPEED_W:0] FullCount = {1'b1, {SPEED_W{1'b0}}};
  // Watchdog fires when the count is about to reach all-ones, which makes
  // error_out rise 2^TIMEOUT_W - 1 cycles after COMPUTE entry.
  localparam logic [TIMEOUT_W-1:0] WdLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 step_pending_q, step_pending_d;
  logic [GEN_W-1:0]     gen_cnt_q, gen_cnt_d;
  logic                 error_q, error_d;

  logic [SPEED_W:0]     period;
  logic [SPEED_W:0]     frame_next;
  logic                 frame_tick;
  logic                 period_met;

  // Frame pacing decode: a frame counts only when auto-advance is enabled
  always_comb begin
    period     = FullCount - {1'b0, bus.speed_in};
    frame_next = {1'b0, frame_cnt_q} + {{SPEED_W{1'b0}}, 1'b1};
    frame_tick = bus.render_done_in && !bus.pause_in && (bus.speed_in != '0);
    period_met = (frame_next >= period);
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: frame pacing, watchdog, pending step, counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_cnt_q    <= '0;
      wd_cnt_q       <= '0;
      step_pending_q <= 1'b0;
      gen_cnt_q      <= '0;
      error_q        <= 1'b0;
    end else begin
      frame_cnt_q    <= frame_cnt_d;
      wd_cnt_q       <= wd_cnt_d;
      step_pending_q <= step_pending_d;
      gen_cnt_q      <= gen_cnt_d;
      error_q        <= error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    wd_cnt_d       = wd_cnt_q;
    step_pending_d = step_pending_q;
    gen_cnt_d      = gen_cnt_q;
    error_d        = error_q;

    // A step arriving while busy is remembered; repeats collapse into one
    if (bus.step_in && (state_q != StIdle)) begin
      step_pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // Explicit steps launch regardless of pause or speed
        if (step_pending_q || bus.step_in) begin
          state_d        = StStart;
          step_pending_d = 1'b0;
        end else if (frame_tick) begin
          if (period_met) begin
            state_d = StStart;
          end else begin
            frame_cnt_d = frame_next[SPEED_W-1:0];
          end
        end
      end

      StStart: begin
        state_d  = StCompute;
        wd_cnt_d = '0;
      end

      StCompute: begin
        if (bus.logic_done_in) begin
          state_d = StWaitSwap;
        end else begin
          wd_cnt_d = wd_cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
          // Abandon the generation: no swap, no count, restart frame pacing
          if (wd_cnt_q == WdLast) begin
            error_d     = 1'b1;
            state_d     = StIdle;
            frame_cnt_d = '0;
          end
        end
      end

      StWaitSwap: begin
        // Swap only on a frame boundary with the buffer ready; otherwise
        // the frame is skipped and the next one is awaited
        if (bus.render_done_in && bus.buf_ready_in) begin
          state_d = StSwap;
        end
      end

      StSwap: begin
        state_d     = StIdle;
        gen_cnt_d   = gen_cnt_q + {{(GEN_W-1){1'b0}}, 1'b1};
        frame_cnt_d = '0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.logic_start_out = (state_q == StStart);
    bus.buf_swap_out    = (state_q == StSwap);
    bus.busy_out        = (state_q != StIdle);
    bus.gen_count_out   = gen_cnt_q;
    bus.error_out       = error_q;
  end

endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: randomized and directed stimulus, a reference model
// tracking the generation life cycle, and a scoreboard monitor.
module tb_gen_scheduler;

  localparam int unsigned SW = 4;
  localparam int unsigned GW = 16;
  localparam int unsigned TW = 4;
  localparam int FramesFull = 1 << SW;
  localparam int WdLimit    = (1 << TW) - 1;
  localparam int GenMod     = 1 << GW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  gen_scheduler_if #(.SPEED_W(SW), .GEN_W(GW)) bus ();

  gen_scheduler #(
    .SPEED_W  (SW),
    .GEN_W    (GW),
    .TIMEOUT_W(TW)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // kind: 0 = start pulse, 1 = swap pulse, 2 = error rise
  typedef struct {
    int kind;
    int cyc;
    int gens;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Reference model of one generation's life: launched -> computing ->
  // computed (awaiting frame) -> swapping -> back to idle
  bit m_launch, m_comp, m_wait, m_swap, m_pend, m_err;
  int m_frames, m_age, m_lat, m_gens;

  // Stimulus knobs
  bit k_pause, k_ready, k_rd_on_ld, k_spur, k_levels, k_step_now;
  int k_speed, k_lat, k_step_rate, k_rd_period;

  function automatic string kname(input int kind);
    case (kind)
      0:       return "start";
      1:       return "swap";
      default: return "error";
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t cyc=%0d)", name, act, req, $time, cyc);
    end
  endtask

  task automatic push(input int kind);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.gens = m_gens;
    expq.push_back(e);
  endtask

  function automatic bit m_idle();
    return !(m_launch || m_comp || m_wait || m_swap);
  endfunction

  task automatic model_clear();
    m_launch = 0; m_comp = 0; m_wait = 0; m_swap = 0; m_pend = 0; m_err = 0;
    m_frames = 0; m_age = 0; m_lat = 0; m_gens = 0;
  endtask

  // Advance the model across one clock edge given the inputs seen at that edge
  task automatic model(input bit st, input bit rd, input bit ld, input bit rdy, input bit ps,
                       input int spd);
    bit was_idle;
    was_idle = m_idle();
    if (m_launch) begin
      m_launch = 0;
      m_comp   = 1;
      m_age    = 0;
      if (k_lat < 0) m_lat = ($urandom_range(0, 9) == 0) ? 1000 : $urandom_range(0, 13);
      else           m_lat = k_lat;
    end else if (m_comp) begin
      if (ld) begin
        m_comp = 0;
        m_wait = 1;
      end else begin
        m_age++;
        if (m_age == WdLimit) begin
          m_comp   = 0;
          m_frames = 0;
          if (!m_err) push(2);
          m_err = 1;
        end
      end
    end else if (m_wait) begin
      if (rd && rdy) begin
        m_wait = 0;
        m_swap = 1;
        push(1);
      end
    end else if (m_swap) begin
      m_swap   = 0;
      m_gens   = (m_gens + 1) % GenMod;
      m_frames = 0;
    end else begin
      if (m_pend || st) begin
        m_pend   = 0;
        m_launch = 1;
        push(0);
      end else if (rd && !ps && spd != 0) begin
        if (m_frames + 1 >= FramesFull - spd) begin
          m_launch = 1;
          push(0);
        end else begin
          m_frames++;
        end
      end
    end
    if (st && !was_idle) m_pend = 1;
  endtask

  // Drive n cycles; inputs applied 1 time unit after the active edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bit st, rd, ld;
      if (k_levels) begin
        if ($urandom_range(0, 29) == 0) k_ready = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 99) == 0) k_pause = ~k_pause;
        if ($urandom_range(0, 79) == 0) k_speed = $urandom_range(0, 15);
      end
      st = k_step_now || (k_step_rate > 0 && $urandom_range(0, k_step_rate - 1) == 0);
      k_step_now = 0;
      rd = (k_rd_period > 0) ? (cyc % k_rd_period == 0) : ($urandom_range(0, 4) == 0);
      ld = m_comp && (m_age == m_lat);
      if (!m_comp && k_spur && $urandom_range(0, 19) == 0) ld = 1;
      if (k_rd_on_ld && ld) rd = 1;
      bus.step_in        = st;
      bus.render_done_in = rd;
      bus.logic_done_in  = ld;
      bus.buf_ready_in   = k_ready;
      bus.pause_in       = k_pause;
      bus.speed_in       = SW'(k_speed);
      @(posedge clk);
      cyc++;
      model(st, rd, ld, k_ready, k_pause, k_speed);
      #1;
      bus.step_in        = 1'b0;
      bus.render_done_in = 1'b0;
      bus.logic_done_in  = 1'b0;
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_start"}, bus.logic_start_out, 0);
    check({pfx, "_swap"}, bus.buf_swap_out, 0);
    check({pfx, "_busy"}, bus.busy_out, 0);
    check({pfx, "_gen_count"}, bus.gen_count_out, 0);
    check({pfx, "_error"}, bus.error_out, 0);
  endtask

  task automatic phase_check(input string pfx);
    check({pfx, "_gen_count"}, bus.gen_count_out, m_gens);
    check({pfx, "_error"}, bus.error_out, m_err);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT shows an event
  task automatic take(input int kind);
    ev_t e;
    if (expq.size() == 0) begin
      check({"unexpected_", kname(kind)}, cyc, -1);
      return;
    end
    e = expq.pop_front();
    check({kname(e.kind), "_kind"}, kind, e.kind);
    check({kname(e.kind), "_cycle"}, cyc, e.cyc);
    check({kname(e.kind), "_gen_count"}, bus.gen_count_out, e.gens);
  endtask

  initial begin : monitor
    bit err_prev;
    err_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        err_prev = 0;
      end else begin
        if (bus.logic_start_out) begin
          take(0);
          check("start_busy", bus.busy_out, 1);
        end
        if (bus.buf_swap_out) begin
          take(1);
          check("swap_busy", bus.busy_out, 1);
        end
        if (bus.error_out && !err_prev) take(2);
        err_prev = bus.error_out;
      end
    end
  end

  initial begin : stimulus
    bus.step_in        = 1'b0;
    bus.render_done_in = 1'b0;
    bus.logic_done_in  = 1'b0;
    bus.buf_ready_in   = 1'b0;
    bus.pause_in       = 1'b0;
    bus.speed_in       = '0;
    model_clear();
    k_pause = 0; k_ready = 1; k_rd_on_ld = 0; k_spur = 0; k_levels = 0; k_step_now = 0;
    k_speed = 0; k_lat = 10; k_step_rate = 0; k_rd_period = 6;

    // Power-on reset, asserted asynchronously between edges
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // Speed pacing: period 3 frames, compute latency 10
    k_speed = 13;
    run(12 * 6);
    phase_check("pacing");

    // Paused: frames alone must not launch
    k_pause = 1;
    run(5 * 6);
    phase_check("paused");
    // Step while paused, then a second step during COMPUTE
    k_step_now = 1;
    run(3);
    k_step_now = 1;
    run(80);
    phase_check("step");

    // Swap gating: buffer not ready for several frames after compute
    k_pause = 0; k_speed = 15; k_ready = 0; k_rd_period = 8;
    run(60);
    k_ready = 1;
    run(40);
    phase_check("gating");

    // logic_done coinciding with render_done
    k_rd_on_ld = 1; k_rd_period = 7; k_lat = 4;
    run(80);
    k_rd_on_ld = 0;
    phase_check("simultaneous");

    // Watchdog: compute never completes
    k_pause = 1; k_lat = 1000;
    run(10);
    k_step_now = 1;
    run(40);
    k_lat = 5;
    phase_check("watchdog");

    // Randomized traffic
    k_levels = 1; k_lat = -1; k_step_rate = 40; k_spur = 1; k_rd_period = 0;
    run(2500);
    phase_check("random1");

    // Asynchronous reset while waiting for a swap
    k_levels = 0; k_pause = 1; k_ready = 0; k_lat = 3; k_step_rate = 0; k_spur = 0;
    k_rd_period = 6;
    k_step_now = 1;
    for (int i = 0; i < 60 && !m_wait; i++) run(1);
    check("reach_wait_swap", m_wait, 1);
    check("pre_reset_queue", expq.size(), 0);
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    expq.delete();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    k_pause = 0; k_ready = 1; k_speed = 13; k_lat = 6;
    run(60);
    phase_check("after_reset");

    // More randomized traffic
    k_levels = 1; k_lat = -1; k_step_rate = 30; k_spur = 1; k_rd_period = 0;
    run(1500);

    // Drain to idle
    k_levels = 0; k_pause = 1; k_speed = 0; k_ready = 1; k_step_rate = 0; k_spur = 0;
    k_lat = 2; k_rd_period = 4;
    for (int i = 0; i < 500; i++) begin
      if (m_idle() && !m_pend && expq.size() == 0) break;
      run(1);
    end
    run(2);
    check("final_busy", bus.busy_out, !m_idle());
    check("final_queue", expq.size(), 0);
    phase_check("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
